stopwatch_ctrl: RTL and testbench

//  Front-end control stage for the stopwatch counter/display block. Synchronises and

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_ctrl_debounce.sv | 57 +++++
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control front end.
// Lap support is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam int CLK_FREQ_DEF = 100_000_000;
  localparam int DEBOUNCE_MS  = 10;

  typedef struct packed {
    logic start;
    logic clear;
    logic lap;
  } btn_evt_t;

  function automatic int db_cycles(
    input int freq,
    input int ms
  );
    return freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button input path: 2-FF synchroniser, stability counter, press strobe.
// Press is suppressed until the button has been seen released after reset.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q;
  logic          lvl_d_q;
  logic          armed_q;
  logic          synced;

  assign synced = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      lvl_d_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      vld_q   <= {vld_q[0], 1'b1};
      lvl_d_q <= lvl_q;
      if (synced == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        lvl_q <= ~lvl_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      // vld_q[1] means synced now reflects a real post-reset sample
      if (vld_q[1] && !lvl_q && !synced) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign level = lvl_q;
  assign press = lvl_q & ~lvl_d_q & armed_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/pause/clear control with debounced buttons.
// Define STOPWATCH_LAP_EN to build the lap debouncer and LAP state.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ        = CLK_FREQ_DEF,
  parameter int DEBOUNCE_CYCLES = db_cycles(CLK_FREQ, DEBOUNCE_MS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       run_en,
  output logic       clr_pulse,
  output logic       disp_freeze,
  output logic [1:0] state
);

  btn_evt_t  evt;
  sw_state_e cur_q;
  sw_state_e nxt;
  logic      clr_nxt;
  logic      clr_q;
  logic      run_q;
  logic      start_p;
  logic      clear_p;
  logic      lap_p;
  logic      lvl_s;
  logic      lvl_c;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_start_stop),
    .level  (lvl_s),
    .press  (start_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clear (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_clear),
    .level  (lvl_c),
    .press  (clear_p)
  );

`ifdef STOPWATCH_LAP_EN
  logic lvl_l;
  logic lvl_unused;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_lap (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_lap),
    .level  (lvl_l),
    .press  (lap_p)
  );

  assign lvl_unused = ^{lvl_s, lvl_c, lvl_l};
`else
  logic lvl_unused;

  assign lap_p      = 1'b0;
  assign lvl_unused = ^{lvl_s, lvl_c, btn_lap, evt.lap};
`endif

  assign evt = '{start: start_p, clear: clear_p, lap: lap_p};

  always_comb begin
    nxt     = cur_q;
    clr_nxt = 1'b0;
    case (cur_q)
      ST_IDLE: begin
        if (evt.clear) begin
          clr_nxt = 1'b1;
        end else if (evt.start) begin
          nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (evt.start) begin
          nxt = ST_PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (evt.lap) begin
          nxt = ST_LAP;
        end
`endif
      end
      ST_PAUSE: begin
        if (evt.clear) begin
          clr_nxt = 1'b1;
          nxt     = ST_IDLE;
        end else if (evt.start) begin
          nxt = ST_RUN;
        end
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (evt.start) begin
          nxt = ST_PAUSE;
        end else if (evt.lap) begin
          nxt = ST_RUN;
        end
      end
`endif
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= ST_IDLE;
      clr_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cur_q <= nxt;
      clr_q <= clr_nxt;
      run_q <= (nxt == ST_RUN) || (nxt == ST_LAP);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic frz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz_q <= 1'b0;
    end else begin
      frz_q <= (nxt == ST_LAP);
    end
  end

  assign disp_freeze = frz_q;
`else
  assign disp_freeze = 1'b0;
`endif

  assign run_en    = run_q;
  assign clr_pulse = clr_q;
  assign state     = cur_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl, DEBOUNCE_CYCLES=4.
// Inputs change on negedge; outputs are checked on negedge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       run_en;
  logic       clr_pulse;
  logic       disp_freeze;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int clr_seen = 0;
  int st_chg   = 0;
  logic [1:0] prev_st = 2'd0;
  int c0;

  stopwatch_ctrl #(
    .CLK_FREQ       (100_000_000),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .btn_lap       (btn_lap),
    .run_en        (run_en),
    .clr_pulse     (clr_pulse),
    .disp_freeze   (disp_freeze),
    .state         (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (clr_pulse) clr_seen++;
    if (state != prev_st) st_chg++;
    prev_st = state;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(
    input logic s,
    input logic c,
    input logic l,
    input int   hold,
    input int   gap
  );
    btn_start_stop = s;
    btn_clear      = c;
    btn_lap        = l;
    tick(hold);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    tick(gap);
  endtask

  initial begin
    rst            = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    tick(2);
    chk("rst_run", run_en, 0);
    chk("rst_clr", clr_pulse, 0);
    chk("rst_frz", disp_freeze, 0);
    chk("rst_st", state, 0);
    rst = 1'b0;
    tick(5);

    // start from IDLE: 2 sync + 4 debounce + 1 output
    c0 = st_chg;
    btn_start_stop = 1'b1;
    tick(6);
    chk("lat_early_st", state, 0);
    chk("lat_early_run", run_en, 0);
    tick(1);
    chk("lat_st", state, 1);
    chk("lat_run", run_en, 1);
    tick(13);
    btn_start_stop = 1'b0;
    tick(12);
    chk("hold_single", st_chg - c0, 1);
    chk("release_st", state, 1);

    // clear ignored in RUN
    c0 = clr_seen;
    push(1'b0, 1'b1, 1'b0, 10, 10);
    chk("run_clr_pulse", clr_seen - c0, 0);
    chk("run_clr_st", state, 1);
    push(1'b1, 1'b0, 1'b0, 10, 10);
    chk("pause_st", state, 2);
    chk("pause_run", run_en, 0);

    // bounce 1-0-1-0 then stable: one PAUSE->RUN toggle
    c0 = st_chg;
    btn_start_stop = 1'b1; tick(1);
    btn_start_stop = 1'b0; tick(1);
    btn_start_stop = 1'b1; tick(1);
    btn_start_stop = 1'b0; tick(1);
    btn_start_stop = 1'b1; tick(12);
    btn_start_stop = 1'b0; tick(10);
    chk("bounce_chg", st_chg - c0, 1);
    chk("bounce_st", state, 1);
    chk("bounce_run", run_en, 1);

    // PAUSE, start+clear together: clear wins
    push(1'b1, 1'b0, 1'b0, 10, 10);
    chk("pause2_st", state, 2);
    c0 = clr_seen;
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    tick(7);
    chk("both_clr_hi", clr_pulse, 1);
    chk("both_st", state, 0);
    tick(1);
    chk("both_clr_lo", clr_pulse, 0);
    tick(5);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    tick(10);
    chk("both_clr_cnt", clr_seen - c0, 1);
    chk("both_st_end", state, 0);
    chk("both_run", run_en, 0);

    // reset mid-press
    btn_start_stop = 1'b1;
    tick(10);
    chk("pre_rst_st", state, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_st", state, 0);
    chk("async_run", run_en, 0);
    chk("async_clr", clr_pulse, 0);
    tick(3);
    rst = 1'b0;
    tick(20);
    chk("held_st", state, 0);
    chk("held_run", run_en, 0);
    btn_start_stop = 1'b0;
    tick(10);
    chk("rel_st", state, 0);
    push(1'b1, 1'b0, 1'b0, 10, 5);
    chk("repress_st", state, 1);
    chk("repress_run", run_en, 1);

`ifdef STOPWATCH_LAP_EN
    push(1'b0, 1'b0, 1'b1, 10, 5);
    chk("lap_st", state, 3);
    chk("lap_frz", disp_freeze, 1);
    chk("lap_run", run_en, 1);
    push(1'b0, 1'b0, 1'b1, 10, 5);
    chk("unlap_st", state, 1);
    chk("unlap_frz", disp_freeze, 0);
    chk("unlap_run", run_en, 1);
`else
    push(1'b0, 1'b0, 1'b1, 10, 5);
    chk("nolap_st", state, 1);
    chk("nolap_frz", disp_freeze, 0);
    chk("nolap_run", run_en, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
